play_core: RTL and testbench
============================

Name: play_core

Overview:
- Playback engine: the read-side counterpart of the recording path.
- On command from the top-level controller, fetches 32-bit stereo samples (left in [31:16], right in [15:0]) from a contiguous SDRAM word range.
- Buffers the samples in a small prefetch FIFO and streams them to the audio DAC interface over a valid/ready handshake.
- Sits between the controller, the SDRAM arbiter port and the audio output block.

Parameters:
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, 2..16
- ADDR_W, 23, SDRAM word address width
- DATA_W, 32, sample width

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous active-high reset
- play_start  input  1  one-cycle pulse; begin playback; ignored unless IDLE
- play_start_addr  input  ADDR_W  first word address, sampled on play_start
- play_end_addr  input  ADDR_W  last word address (inclusive), sampled on play_start
- play_pause  input  1  level; while high, no new reads issued and audio output held
- play_stop  input  1  one-cycle pulse; abort playback
- play_done  output  1  one-cycle pulse at end of playback or abort
- play_read  output  1  SDRAM read request; held until play_sdram_finished
- play_addr  output  ADDR_W  SDRAM address; stable while play_read high
- play_readdata  input  DATA_W  SDRAM data; valid in play_sdram_finished cycle
- play_sdram_finished  input  1  one-cycle completion pulse from SDRAM
- play_audio_data  output  DATA_W  sample to DAC (FIFO head)
- play_audio_valid  output  1  play_audio_data valid
- play_audio_ready  input  1  DAC accepts; transfer occurs when valid && ready

Behaviour:
- Reset, synchronous to i_rst high:
  - State goes to IDLE; FIFO is emptied; fetch pointer is cleared.
  - play_read, play_done and play_audio_valid are 0; play_addr and play_audio_data are 0.
  - Reset mid-transaction drops play_read immediately. A late play_sdram_finished in IDLE is ignored.
- States: IDLE, RUN, DRAIN, ABORT, DONE.
- IDLE:
  - On play_start, latch the address range, set fetch pointer to start, flush FIFO.
  - If start > end, go to DONE; otherwise go to RUN.
- RUN:
  - play_read asserts the cycle after a read may be issued: FIFO count plus outstanding < FIFO_DEPTH, pointer <= end, and play_pause low.
  - At most one read is outstanding. play_addr equals the pointer.
  - On play_sdram_finished: play_readdata is pushed, play_read drops that same cycle, and the pointer increments.
  - Once the last address completes, go to DRAIN.
- DRAIN: no reads are issued. When the FIFO is empty and no transfer is pending, go to DONE.
- Audio output (RUN and DRAIN):
  - play_audio_valid = FIFO not empty and play_pause low.
  - play_audio_data = FIFO head, combinational from the FIFO read pointer.
  - A pop occurs on valid && ready.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
- Pause:
  - A read already issued completes and its data is pushed.
  - play_audio_valid is forced low; FIFO contents are kept.
  - Deasserting pause resumes with no sample lost or duplicated.
- Stop, from RUN or DRAIN; priority over pause and over normal completion in the same cycle:
  - If a read is outstanding, go to ABORT. play_read stays high until finished, and the returned data is discarded.
  - Then flush the FIFO and go to DONE.
  - play_audio_valid is low from the cycle after the stop pulse.
- DONE: play_done = 1 for exactly one cycle, then go to IDLE.
- Arithmetic:
  - The pointer is ADDR_W bits.
  - end = 2^ADDR_W - 1 is legal: the completion check uses the pre-increment compare (pointer == end), so the range terminates and does not wrap.
- The FIFO never overflows by construction (credit check includes outstanding). A push into a full FIFO is an assertion failure.

Optional Feature:
- PLAY_LOOP_EN.
- When defined: on completion of the read at end, the pointer reloads start_addr and RUN continues. Playback is seamless, with no DRAIN and no play_done; only play_stop terminates it.
- When undefined: behaviour is as above, with one pass and play_done after drain.

Decomposition:
- Shared package play_pkg:
  - state enum play_state_t {IDLE, RUN, DRAIN, ABORT, DONE}
  - localparam SAMPLE_W = 32
  - address type typedef logic [22:0] sdram_addr_t, shared with the recording core.
- One natural sub-module: play_fifo, a synchronous FIFO.
  - Interface: push/pop/full/empty/count, with a registered storage array.
  - Synchronous flush.
  - Reusable by the recording core's buffering.

Test Plan:
1. Start 0x000100..0x000103, SDRAM finished latency 3, DAC ready always high -> reads at 0x100..0x103 in order; 4 samples out matching memory; play_done one cycle after last pop.
2. Start 0x10..0x1F, ready low -> exactly FIFO_DEPTH=4 reads then play_read stays 0; raising ready resumes, all 16 delivered in order.
3. Pause asserted for 20 cycles mid-range with a read outstanding -> that read completes and is pushed; valid low throughout; after release there are no gaps or duplicates vs. memory image.
4. play_stop while play_read high -> play_read held until finished, data discarded, valid 0 next cycle, play_done pulse, return to IDLE; subsequent play_start works.
5. start=0x20, end=0x1F -> no reads, play_done 1 cycle after start; end=0x7FFFFF single word -> one read, no wrap.
6. With PLAY_LOOP_EN, range 0x0..0x2 -> addresses 0,1,2,0,1,2,... and no play_done until play_stop.

Source files
------------

// File: rtl/play_pkg.sv
// play_pkg: definitions shared by the playback core and its FIFO.
//   play_state_t : playback controller states
//   SAMPLE_W     : stereo sample width (left [31:16], right [15:0])
//   sdram_addr_t : SDRAM word address, shared with the recording core
package play_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    ABORT,
    DONE
  } play_state_t;

  localparam int SAMPLE_W = 32;

  typedef logic [22:0] sdram_addr_t;

endpackage

// File: rtl/play_fifo.sv
// play_fifo: synchronous FIFO with registered storage and synchronous flush.
// Ports:
//   clk, rst       clock, synchronous active-high reset (pointers/count only)
//   flush          empties the FIFO; wins over push and pop in the same cycle
//   push, wdata    write request and data
//   pop            read request; rdata is the current head (combinational)
//   full, empty    status flags
//   count          number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module play_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees the slot.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst || flush)
    !(push && full && !pop));

endmodule

// File: rtl/play_core.sv
// play_core: playback engine. Fetches stereo samples from a contiguous SDRAM
// word range, buffers them in a prefetch FIFO and streams them to the DAC.
// Ports:
//   i_clk, i_rst                          clock, synchronous active-high reset
//   play_start/_start_addr/_end_addr      start pulse and inclusive word range
//   play_pause                            level: hold reads and audio output
//   play_stop                             pulse: abort playback
//   play_done                             one-cycle end/abort pulse
//   play_read/_addr/_readdata/_sdram_finished   SDRAM read port
//   play_audio_data/_valid/_ready         DAC valid/ready stream
// Build option: define PLAY_LOOP_EN to replay the range endlessly until stop.
module play_core
  import play_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = $bits(sdram_addr_t),
  parameter int DATA_W     = SAMPLE_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              play_start,
  input  logic [ADDR_W-1:0] play_start_addr,
  input  logic [ADDR_W-1:0] play_end_addr,
  input  logic              play_pause,
  input  logic              play_stop,
  output logic              play_done,
  output logic              play_read,
  output logic [ADDR_W-1:0] play_addr,
  input  logic [DATA_W-1:0] play_readdata,
  input  logic              play_sdram_finished,
  output logic [DATA_W-1:0] play_audio_data,
  output logic              play_audio_valid,
  input  logic              play_audio_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  play_state_t       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              read_q, read_d;

  logic              fifo_flush, fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_rdata;

  logic              active;
  logic              rd_done;
  logic              can_issue;
  logic              drain_empty;

  assign active  = (state_q == RUN) || (state_q == DRAIN);
  assign rd_done = read_q && play_sdram_finished;

  assign play_audio_valid = active && !fifo_empty && !play_pause;
  // Storage is not reset, so the head is masked while nothing is buffered.
  assign play_audio_data  = fifo_empty ? '0 : fifo_rdata;
  assign fifo_pop         = play_audio_valid && play_audio_ready;

  assign play_read = read_q;
  assign play_addr = ptr_q;
  assign play_done = (state_q == DONE);

  // Only one read is ever outstanding, so with read_q low the credit check
  // (count + outstanding < depth) reduces to "FIFO not full".
  assign can_issue = !read_q && !fifo_full && (ptr_q <= end_q) && !play_pause;

  // The last sample leaving this cycle ends the drain without an idle cycle.
  assign drain_empty = (fifo_count == '0) ||
                       ((fifo_count == CNT_W'(1)) && fifo_pop);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    start_d    = start_q;
    end_d      = end_q;
    read_d     = read_q;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (play_start) begin
          start_d    = play_start_addr;
          end_d      = play_end_addr;
          ptr_d      = play_start_addr;
          fifo_flush = 1'b1;
          state_d    = (play_start_addr > play_end_addr) ? DONE : RUN;
        end
      end

      RUN: begin
        if (play_stop) begin
          fifo_flush = 1'b1;
          if (read_q && !play_sdram_finished) begin
            state_d = ABORT;
          end else begin
            read_d  = 1'b0;
            state_d = DONE;
          end
        end else if (rd_done) begin
          fifo_push = 1'b1;
          read_d    = 1'b0;
          // Pre-increment compare so an end address of all-ones terminates.
          if (ptr_q == end_q) begin
`ifdef PLAY_LOOP_EN
            ptr_d = start_q;
`else
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = DRAIN;
`endif
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end else if (can_issue) begin
          read_d = 1'b1;
        end
      end

      DRAIN: begin
        if (play_stop) begin
          fifo_flush = 1'b1;
          state_d    = DONE;
        end else if (drain_empty) begin
          state_d = DONE;
        end
      end

      ABORT: begin
        // Hold the request until SDRAM answers; the returned word is dropped.
        fifo_flush = 1'b1;
        if (play_sdram_finished) begin
          read_d  = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      read_q  <= read_d;
    end
  end

  always_ff @(posedge i_clk) begin
    start_q <= start_d;
    end_q   <= end_d;
  end

  play_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (play_readdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_play_core.sv
// tb_play_core: self-checking bench for play_core. An SDRAM responder and a
// DAC-ready driver surround the DUT; a queue-based model of the address range
// supplies the expected read addresses and samples.
`timescale 1ns/1ps
module tb_play_core;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 23;
  localparam int DATA_W     = 32;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              play_start;
  logic [ADDR_W-1:0] play_start_addr;
  logic [ADDR_W-1:0] play_end_addr;
  logic              play_pause;
  logic              play_stop;
  logic              play_done;
  logic              play_read;
  logic [ADDR_W-1:0] play_addr;
  logic [DATA_W-1:0] play_readdata;
  logic              play_sdram_finished;
  logic [DATA_W-1:0] play_audio_data;
  logic              play_audio_valid;
  logic              play_audio_ready;

  always #5 i_clk = ~i_clk;

  play_core #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .play_start          (play_start),
    .play_start_addr     (play_start_addr),
    .play_end_addr       (play_end_addr),
    .play_pause          (play_pause),
    .play_stop           (play_stop),
    .play_done           (play_done),
    .play_read           (play_read),
    .play_addr           (play_addr),
    .play_readdata       (play_readdata),
    .play_sdram_finished (play_sdram_finished),
    .play_audio_data     (play_audio_data),
    .play_audio_valid    (play_audio_valid),
    .play_audio_ready    (play_audio_ready)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: event not as required", name);
  endtask

  // Memory image: every word is a fixed scramble of its address.
  function automatic logic [31:0] mem_word(input logic [22:0] a);
    return ({9'd0, a} * 32'h9E3779B1) ^ 32'h5EED1234;
  endfunction

  // Reference model: the range in order, one sample per word.
  logic [22:0] exp_addr[$];
  logic [31:0] exp_data[$];

  task automatic load_model(input logic [22:0] s, input logic [22:0] e);
    exp_addr.delete();
    exp_data.delete();
    for (int a = int'(s); a <= int'(e); a++) begin
      exp_addr.push_back(23'(a));
      exp_data.push_back(mem_word(23'(a)));
    end
  endtask

  // Environment knobs and observation counters.
  int sd_lat = 3;        // 0 = random 1..5 per read
  int rdy_mode = 0;      // 0 = ready high, 1 = ready low, 2 = random
  int inj_req = 0;
  int inj_ack = 0;
  int cyc = 0;
  int n_reads = 0, n_pops = 0, n_fin = 0, done_cnt = 0;
  int last_pop_cyc = 0, done_cyc = 0, rises_in_pause = 0;
  bit no_pop_window = 1'b0;
  bit prev_read = 1'b0, prev_done = 1'b0, prev_pause = 1'b0;
  logic [22:0] held_addr = '0;

  always @(posedge i_clk) cyc++;

  // SDRAM responder: finished pulse after the configured latency.
  initial begin
    int lat_cnt;
    int cur_lat;
    lat_cnt = 0;
    cur_lat = 1;
    play_sdram_finished = 1'b0;
    play_readdata = '0;
    forever begin
      @(posedge i_clk); #1;
      if (play_sdram_finished) begin
        play_sdram_finished = 1'b0;
        lat_cnt = 0;
      end else if (inj_req != inj_ack) begin
        inj_ack = inj_req;
        play_sdram_finished = 1'b1;
        play_readdata = 32'hBAD0BAD0;
      end else if (play_read) begin
        if (lat_cnt == 0) cur_lat = (sd_lat == 0) ? int'($urandom_range(1, 5)) : sd_lat;
        lat_cnt++;
        if (lat_cnt >= cur_lat) begin
          play_sdram_finished = 1'b1;
          play_readdata = mem_word(play_addr);
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // DAC ready driver.
  initial begin
    play_audio_ready = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      if (rdy_mode == 2) play_audio_ready = 1'($urandom_range(0, 1));
      else play_audio_ready = (rdy_mode == 0);
    end
  end

  // Monitor: reads, samples, pause behaviour and done pulses.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (play_read && !prev_read) begin
        n_reads++;
        held_addr = play_addr;
        if (play_pause && prev_pause) rises_in_pause++;
        if (exp_addr.size() == 0) fail_now("unexpected_read");
        else check("read_addr", 32'(play_addr), 32'(exp_addr.pop_front()));
      end else if (play_read && prev_read) begin
        check("addr_stable", 32'(play_addr), 32'(held_addr));
      end
      if (play_sdram_finished) n_fin++;
      if (play_audio_valid && play_audio_ready) begin
        n_pops++;
        last_pop_cyc = cyc;
        if (no_pop_window) fail_now("pop_after_stop");
        else if (exp_data.size() == 0) fail_now("extra_sample");
        else check("sample", play_audio_data, exp_data.pop_front());
      end
      if (play_pause) check("valid_in_pause", 32'(play_audio_valid), 32'd0);
      if (play_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (prev_done) fail_now("done_width");
      end
    end
    prev_read  = play_read;
    prev_done  = play_done;
    prev_pause = play_pause;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic start_play(input logic [22:0] s, input logic [22:0] e, output int scyc);
    play_start_addr = s;
    play_end_addr   = e;
    play_start      = 1'b1;
    scyc            = cyc;
    tick(1);
    play_start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int i = 0;
    while (done_cnt == d0 && i < 3000) begin tick(1); i++; end
    if (done_cnt == d0) fail_now({name, "_done_timeout"});
  endtask

  task automatic wait_read(input string name, input int r0, input int need);
    int i = 0;
    while (!(play_read && (n_reads - r0) >= need) && i < 500) begin tick(1); i++; end
    if (i >= 500) fail_now({name, "_read_timeout"});
  endtask

  typedef struct {
    logic [22:0] s;
    logic [22:0] e;
    int          lat;
    int          rdy;
    int          pause_at;
    int          pause_len;
    int          exp_reads;
  } vec_t;

  task automatic run_vec(input string name, input vec_t v);
    int r0, p0, d0, scyc, i;
    load_model(v.s, v.e);
    r0 = n_reads; p0 = n_pops; d0 = done_cnt;
    sd_lat = v.lat;
    rdy_mode = v.rdy;
    start_play(v.s, v.e, scyc);
    i = 0;
    while (done_cnt == d0 && i < 3000) begin
      if (v.pause_len > 0 && i == v.pause_at) play_pause = 1'b1;
      if (i == v.pause_at + v.pause_len) play_pause = 1'b0;
      tick(1);
      i++;
    end
    play_pause = 1'b0;
    if (done_cnt == d0) fail_now({name, "_done_timeout"});
    tick(2);
    check({name, "_reads"}, 32'(n_reads - r0), 32'(v.exp_reads));
    check({name, "_samples"}, 32'(n_pops - p0), 32'(v.exp_reads));
    check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_model_drained"}, 32'(exp_addr.size() + exp_data.size()), 32'd0);
    if (v.exp_reads == 0) check({name, "_done_lat"}, 32'(done_cyc), 32'(scyc + 1));
    else check({name, "_done_after_pop"}, 32'(done_cyc), 32'(last_pop_cyc + 1));
  endtask

  initial begin
    vec_t vecs[5];
    int r0, p0, d0, f0, rp0, scyc, len;
    logic [22:0] s;
    vec_t rv;

    vecs[0] = '{23'h000100, 23'h000103, 3, 0, 0, 0, 4};
    vecs[1] = '{23'h000020, 23'h00001F, 3, 0, 0, 0, 0};
    vecs[2] = '{23'h7FFFFF, 23'h7FFFFF, 2, 0, 0, 0, 1};
    vecs[3] = '{23'h000010, 23'h00001F, 0, 2, 12, 20, 16};
    vecs[4] = '{23'h7FFFFD, 23'h7FFFFF, 1, 2, 0, 0, 3};

    i_rst = 1'b1;
    play_start = 1'b0;
    play_start_addr = '0;
    play_end_addr = '0;
    play_pause = 1'b0;
    play_stop = 1'b0;
    tick(3);
    check("rst_read", 32'(play_read), 32'd0);
    check("rst_valid", 32'(play_audio_valid), 32'd0);
    check("rst_done", 32'(play_done), 32'd0);
    check("rst_addr", 32'(play_addr), 32'd0);
    check("rst_data", play_audio_data, 32'd0);
    i_rst = 1'b0;
    tick(2);

`ifdef PLAY_LOOP_EN
    // Endless replay of 0..2 until stopped.
    exp_addr.delete();
    exp_data.delete();
    for (int k = 0; k < 5; k++)
      for (int a = 0; a < 3; a++) begin
        exp_addr.push_back(23'(a));
        exp_data.push_back(mem_word(23'(a)));
      end
    r0 = n_reads; d0 = done_cnt;
    sd_lat = 2; rdy_mode = 0;
    start_play(23'h0, 23'h2, scyc);
    wait_read("loop", r0, 12);
    check("loop_no_done", 32'(done_cnt - d0), 32'd0);
    play_stop = 1'b1;
    tick(1);
    play_stop = 1'b0;
    wait_done("loop", d0);
    check("loop_reads", 32'(n_reads - r0), 32'd12);
    check("loop_done_count", 32'(done_cnt - d0), 32'd1);
    exp_addr.delete();
    exp_data.delete();
`else
    // Table of whole-playback vectors.
    for (int k = 0; k < 5; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

    // DAC stalled: prefetch stops at FIFO depth, then everything flows.
    load_model(23'h10, 23'h1F);
    r0 = n_reads; p0 = n_pops; d0 = done_cnt;
    sd_lat = 2; rdy_mode = 1;
    start_play(23'h10, 23'h1F, scyc);
    tick(40);
    check("stall_reads", 32'(n_reads - r0), 32'(FIFO_DEPTH));
    check("stall_read_low", 32'(play_read), 32'd0);
    check("stall_no_pops", 32'(n_pops - p0), 32'd0);
    rdy_mode = 0;
    wait_done("stall", d0);
    check("stall_total_reads", 32'(n_reads - r0), 32'd16);
    check("stall_total_samples", 32'(n_pops - p0), 32'd16);

    // Pause with a read outstanding.
    load_model(23'h200, 23'h20B);
    r0 = n_reads; p0 = n_pops; d0 = done_cnt;
    sd_lat = 4; rdy_mode = 0;
    start_play(23'h200, 23'h20B, scyc);
    wait_read("pause", r0, 5);
    rp0 = rises_in_pause; f0 = n_fin;
    play_pause = 1'b1;
    tick(20);
    check("pause_read_completed", 32'(n_fin - f0), 32'd1);
    check("pause_no_new_reads", 32'(rises_in_pause - rp0), 32'd0);
    play_pause = 1'b0;
    wait_done("pause", d0);
    check("pause_samples", 32'(n_pops - p0), 32'd12);
    check("pause_model_drained", 32'(exp_data.size()), 32'd0);

    // Stop while a read is outstanding.
    load_model(23'h40, 23'h4F);
    r0 = n_reads; d0 = done_cnt;
    sd_lat = 6; rdy_mode = 0;
    start_play(23'h40, 23'h4F, scyc);
    wait_read("stop", r0, 3);
    f0 = n_fin;
    play_stop = 1'b1;
    tick(1);
    play_stop = 1'b0;
    no_pop_window = 1'b1;
    check("stop_valid_low", 32'(play_audio_valid), 32'd0);
    check("stop_read_held", 32'(play_read), 32'd1);
    wait_done("stop", d0);
    tick(2);
    check("stop_one_finish", 32'(n_fin - f0), 32'd1);
    check("stop_done_count", 32'(done_cnt - d0), 32'd1);
    check("stop_read_low", 32'(play_read), 32'd0);
    no_pop_window = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    run_vec("after_stop", '{23'h300, 23'h305, 2, 0, 0, 0, 6});

    // Reset mid-transaction, then a late finished pulse in IDLE.
    load_model(23'h60, 23'h63);
    r0 = n_reads; d0 = done_cnt;
    sd_lat = 8; rdy_mode = 0;
    start_play(23'h60, 23'h63, scyc);
    wait_read("rstmid", r0, 1);
    i_rst = 1'b1;
    tick(1);
    check("rstmid_read", 32'(play_read), 32'd0);
    check("rstmid_valid", 32'(play_audio_valid), 32'd0);
    check("rstmid_addr", 32'(play_addr), 32'd0);
    i_rst = 1'b0;
    r0 = n_reads;
    inj_req++;
    tick(6);
    check("late_fin_read", 32'(play_read), 32'd0);
    check("late_fin_valid", 32'(play_audio_valid), 32'd0);
    check("late_fin_no_reads", 32'(n_reads - r0), 32'd0);
    check("late_fin_no_done", 32'(done_cnt - d0), 32'd0);
    exp_addr.delete();
    exp_data.delete();

    // Randomized ranges, latencies, DAC back-pressure and pauses.
    for (int k = 0; k < 8; k++) begin
      len = int'($urandom_range(1, 10));
      if (k == 7) s = 23'(24'h800000 - 24'(len));
      else s = 23'($urandom_range(0, 32'h7FFFF0));
      rv = '{s, 23'(int'(s) + len - 1), 0, 2, int'($urandom_range(0, 15)),
             int'($urandom_range(0, 8)), len};
      run_vec($sformatf("rnd%0d", k), rv);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
